// File: rtl/lname_mbus_member_ctrl.sv
// Always-on MBus member controller: power-gate sequencing of the bus controller,
// CIN/DIN bypass while isolated, and member-initiated interrupt on DOUT.
module lname_mbus_member_ctrl #(
  parameter int PG_DLY      = 2,
  parameter int INT_TIMEOUT = 255
) (
  input  logic CLK,
  input  logic RESET,
  input  logic CIN,
  input  logic DIN,
  input  logic COUT_FROM_BUS,
  input  logic DOUT_FROM_BUS,
  output logic COUT,
  output logic DOUT,
  input  logic SLEEP_REQ,
  input  logic INT_REQ,
  output logic MBC_SLEEP,
  output logic MBC_RESET,
  output logic MBC_ISOLATE,
  output logic BUS_ACTIVE,
  output logic INT_ACK,
  output logic INT_ERR
);

  localparam int STG_W = $clog2(PG_DLY + 1);
  localparam int INT_W = $clog2(INT_TIMEOUT + 1);

  localparam logic [STG_W-1:0] STG_ZERO = STG_W'(0);
  localparam logic [STG_W-1:0] STG_ONE  = STG_W'(1);
  localparam logic [STG_W-1:0] STG_LAST = STG_W'(PG_DLY - 1);
  localparam logic [STG_W-1:0] STG_MAX  = STG_W'(PG_DLY);

  localparam logic [INT_W-1:0] INT_ZERO = INT_W'(0);
  localparam logic [INT_W-1:0] INT_ONE  = INT_W'(1);
  localparam logic [INT_W-1:0] INT_LAST = INT_W'(INT_TIMEOUT - 1);

  localparam logic [2:0] ST_SLEEP   = 3'd0;
  localparam logic [2:0] ST_PWR_UP  = 3'd1;
  localparam logic [2:0] ST_RST_REL = 3'd2;
  localparam logic [2:0] ST_ISO_REL = 3'd3;
  localparam logic [2:0] ST_ACTIVE  = 3'd4;
  localparam logic [2:0] ST_ISO_SET = 3'd5;
  localparam logic [2:0] ST_RST_SET = 3'd6;

  logic             cin_meta_r;
  logic             din_meta_r;
  logic             cin_sync_r;
  logic             din_sync_r;
  logic [2:0]       state_r;
  logic [2:0]       state_nxt_s;
  logic [STG_W-1:0] stage_cnt_r;
  logic             stage_done_s;
  logic             sleep_nxt_s;
  logic             reset_nxt_s;
  logic             iso_nxt_s;
  logic             active_nxt_s;
  logic             int_drive_r;
  logic             int_drive_nxt_s;
  logic [INT_W-1:0] int_cnt_r;
  logic [INT_W-1:0] int_cnt_nxt_s;
  logic             int_ack_nxt_s;
  logic             int_err_nxt_s;
  logic             int_idle_s;

  // two-flop synchronisers on the raw wires; an idle bus sits high
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cin_meta_r <= 1'b1;
      din_meta_r <= 1'b1;
      cin_sync_r <= 1'b1;
      din_sync_r <= 1'b1;
    end else begin
      cin_meta_r <= CIN;
      din_meta_r <= DIN;
      cin_sync_r <= cin_meta_r;
      din_sync_r <= din_meta_r;
    end
  end

  // power sequencing next state; timed stages leave after PG_DLY cycles
  always_comb begin
    state_nxt_s  = state_r;
    stage_done_s = (stage_cnt_r == STG_LAST);
    case (state_r)
      ST_SLEEP: begin
        if (!din_sync_r || INT_REQ) state_nxt_s = ST_PWR_UP;
        else                        state_nxt_s = ST_SLEEP;
      end
      ST_PWR_UP: begin
        if (stage_done_s) state_nxt_s = ST_RST_REL;
        else              state_nxt_s = ST_PWR_UP;
      end
      ST_RST_REL: begin
        if (stage_done_s) state_nxt_s = ST_ISO_REL;
        else              state_nxt_s = ST_RST_REL;
      end
      ST_ISO_REL: state_nxt_s = ST_ACTIVE;
      ST_ACTIVE: begin
        if (SLEEP_REQ) state_nxt_s = ST_ISO_SET;
        else           state_nxt_s = ST_ACTIVE;
      end
      ST_ISO_SET: begin
        if (stage_done_s) state_nxt_s = ST_RST_SET;
        else              state_nxt_s = ST_ISO_SET;
      end
      ST_RST_SET: begin
        if (stage_done_s) state_nxt_s = ST_SLEEP;
        else              state_nxt_s = ST_RST_SET;
      end
      default: state_nxt_s = ST_SLEEP;
    endcase
  end

  // gating controls decoded from the state being entered, so they register with it
  always_comb begin
    sleep_nxt_s  = (state_nxt_s == ST_SLEEP);
    reset_nxt_s  = (state_nxt_s == ST_SLEEP) || (state_nxt_s == ST_PWR_UP) ||
                   (state_nxt_s == ST_RST_SET);
    iso_nxt_s    = !((state_nxt_s == ST_ISO_REL) || (state_nxt_s == ST_ACTIVE));
    active_nxt_s = (state_nxt_s == ST_ACTIVE);
  end

  // state, saturating stage counter and registered gating outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r     <= ST_SLEEP;
      stage_cnt_r <= STG_ZERO;
      MBC_SLEEP   <= 1'b1;
      MBC_RESET   <= 1'b1;
      MBC_ISOLATE <= 1'b1;
      BUS_ACTIVE  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (state_nxt_s != state_r)  stage_cnt_r <= STG_ZERO;
      else if (stage_cnt_r != STG_MAX) stage_cnt_r <= stage_cnt_r + STG_ONE;
      else                         stage_cnt_r <= stage_cnt_r;
      MBC_SLEEP   <= sleep_nxt_s;
      MBC_RESET   <= reset_nxt_s;
      MBC_ISOLATE <= iso_nxt_s;
      BUS_ACTIVE  <= active_nxt_s;
    end
  end

  // a fresh request needs an idle bus and a cycle of quiet after the last outcome
  assign int_idle_s = cin_sync_r && din_sync_r && !INT_ACK && !INT_ERR;

  // interrupt drive: master clocking (CIN low) wins over the timeout
  always_comb begin
    int_drive_nxt_s = int_drive_r;
    int_cnt_nxt_s   = int_cnt_r;
    int_ack_nxt_s   = 1'b0;
    int_err_nxt_s   = 1'b0;
    if (int_drive_r) begin
      if (!cin_sync_r) begin
        int_drive_nxt_s = 1'b0;
        int_cnt_nxt_s   = INT_ZERO;
        int_ack_nxt_s   = 1'b1;
      end else if (int_cnt_r == INT_LAST) begin
        int_drive_nxt_s = 1'b0;
        int_cnt_nxt_s   = INT_ZERO;
        int_err_nxt_s   = 1'b1;
      end else begin
        int_cnt_nxt_s   = int_cnt_r + INT_ONE;
      end
    end else if (INT_REQ && int_idle_s) begin
      int_drive_nxt_s = 1'b1;
      int_cnt_nxt_s   = INT_ZERO;
    end else begin
      int_drive_nxt_s = 1'b0;
      int_cnt_nxt_s   = INT_ZERO;
    end
  end

  // interrupt registers and one-cycle outcome pulses
  always_ff @(posedge CLK) begin
    if (RESET) begin
      int_drive_r <= 1'b0;
      int_cnt_r   <= INT_ZERO;
      INT_ACK     <= 1'b0;
      INT_ERR     <= 1'b0;
    end else begin
      int_drive_r <= int_drive_nxt_s;
      int_cnt_r   <= int_cnt_nxt_s;
      INT_ACK     <= int_ack_nxt_s;
      INT_ERR     <= int_err_nxt_s;
    end
  end

  // bypass ring while isolated or in reset; RESET releases DOUT without waiting for an edge
  assign COUT = (RESET || MBC_ISOLATE) ? CIN : COUT_FROM_BUS;
  assign DOUT = RESET       ? DIN  :
                int_drive_r ? 1'b0 :
                MBC_ISOLATE ? DIN  : DOUT_FROM_BUS;

endmodule

// File: tb/tb_lname_mbus_member_ctrl.sv
// Self-checking bench for lname_mbus_member_ctrl: vector table, directed corner
// sequences and random stimulus against a timeline-based reference model.
module tb_lname_mbus_member_ctrl;

  localparam int PG   = 2;
  localparam int TO   = 8;
  localparam int ACT  = 2*PG + 2;   // timeline position of the awake state
  localparam int LAST = 4*PG + 2;   // last position before falling asleep

  logic CLK = 1'b0;
  logic RESET, CIN, DIN, COUT_FROM_BUS, DOUT_FROM_BUS, SLEEP_REQ, INT_REQ;
  logic COUT, DOUT, MBC_SLEEP, MBC_RESET, MBC_ISOLATE, BUS_ACTIVE, INT_ACK, INT_ERR;

  int errors = 0;
  int checks = 0;

  // model: position along wake (1..ACT) then sleep (ACT+1..LAST) timeline, 0 = asleep
  int  m_pos   = 0;
  bit  m_drive = 1'b0;
  int  m_held  = 0;
  bit  m_ack   = 1'b0;
  bit  m_err   = 1'b0;
  bit  m_cq[$] = '{1'b1, 1'b1};
  bit  m_dq[$] = '{1'b1, 1'b1};
  logic obs_cout, obs_dout;

  lname_mbus_member_ctrl #(.PG_DLY(PG), .INT_TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET), .CIN(CIN), .DIN(DIN),
    .COUT_FROM_BUS(COUT_FROM_BUS), .DOUT_FROM_BUS(DOUT_FROM_BUS),
    .COUT(COUT), .DOUT(DOUT), .SLEEP_REQ(SLEEP_REQ), .INT_REQ(INT_REQ),
    .MBC_SLEEP(MBC_SLEEP), .MBC_RESET(MBC_RESET), .MBC_ISOLATE(MBC_ISOLATE),
    .BUS_ACTIVE(BUS_ACTIVE), .INT_ACK(INT_ACK), .INT_ERR(INT_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  // {sleep, reset, isolate, active, ack, err}
  function automatic logic [5:0] m_regs();
    return {m_pos == 0, (m_pos <= PG) || (m_pos >= 3*PG + 3),
            !((m_pos == 2*PG + 1) || (m_pos == ACT)), m_pos == ACT, m_ack, m_err};
  endfunction

  task automatic model_step(input bit rst, input bit cin, input bit din,
                            input bit slp, input bit irq);
    bit c, d, n_ack, n_err;
    if (rst) begin
      m_pos = 0; m_drive = 1'b0; m_held = 0; m_ack = 1'b0; m_err = 1'b0;
      m_cq = '{1'b1, 1'b1}; m_dq = '{1'b1, 1'b1};
    end else begin
      c = m_cq.pop_front(); d = m_dq.pop_front();
      m_cq.push_back(cin); m_dq.push_back(din);
      n_ack = 1'b0; n_err = 1'b0;
      if (m_drive) begin
        if (!c)                begin m_drive = 1'b0; n_ack = 1'b1; end
        else if (m_held == TO) begin m_drive = 1'b0; n_err = 1'b1; end
        else                   m_held++;
      end else if (irq && c && d && !m_ack && !m_err) begin
        m_drive = 1'b1; m_held = 1;
      end
      m_ack = n_ack; m_err = n_err;
      if (m_pos == 0)         m_pos = (!d || irq) ? 1 : 0;
      else if (m_pos == ACT)  m_pos = slp ? ACT + 1 : ACT;
      else if (m_pos == LAST) m_pos = 0;
      else                    m_pos++;
    end
  endtask

  // one clock: drive, check wires, clock, check registered outputs
  task automatic step(input bit rst, input bit cin, input bit din, input bit cfb,
                      input bit dfb, input bit slp, input bit irq);
    logic [5:0] r;
    logic ec, ed;
    RESET = rst; CIN = cin; DIN = din; COUT_FROM_BUS = cfb; DOUT_FROM_BUS = dfb;
    SLEEP_REQ = slp; INT_REQ = irq;
    #1;
    r  = m_regs();
    ec = (rst || r[3]) ? cin : cfb;
    ed = rst ? din : (m_drive ? 1'b0 : (r[3] ? din : dfb));
    obs_cout = COUT; obs_dout = DOUT;
    chk("cout", 6'(COUT), 6'(ec));
    chk("dout", 6'(DOUT), 6'(ed));
    @(posedge CLK);
    model_step(rst, cin, din, slp, irq);
    #1;
    chk("regs", {MBC_SLEEP, MBC_RESET, MBC_ISOLATE, BUS_ACTIVE, INT_ACK, INT_ERR}, m_regs());
  endtask

  typedef struct {
    bit       rst;
    bit       din;
    bit       slp;
    bit [1:0] ewire;   // {COUT, DOUT} before the edge
    bit [3:0] eregs;   // {MBC_SLEEP, MBC_RESET, MBC_ISOLATE, BUS_ACTIVE} after it
  } vec_t;

  vec_t tbl[15];
  int lows, errs, acks, act_cnt, ack_at;

  initial begin
    // wake on DIN low then sleep request; CIN=1, buses from controller = 0
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 2'b11, 4'b1110};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 2'b10, 4'b1110};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 2'b10, 4'b1110};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 2'b11, 4'b0110};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 2'b11, 4'b0110};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 2'b11, 4'b0010};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 2'b11, 4'b0010};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 2'b11, 4'b0000};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 2'b00, 4'b0001};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 2'b00, 4'b0010};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 2'b11, 4'b0010};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 2'b11, 4'b0110};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 2'b11, 4'b0110};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 2'b11, 4'b1110};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 2'b11, 4'b1110};

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].rst, 1'b1, tbl[i].din, 1'b0, 1'b0, tbl[i].slp, 1'b0);
      chk($sformatf("tbl%0d_wire", i), 6'({obs_cout, obs_dout}), 6'(tbl[i].ewire));
      chk($sformatf("tbl%0d_regs", i),
          {MBC_SLEEP, MBC_RESET, MBC_ISOLATE, BUS_ACTIVE, INT_ACK, INT_ERR},
          {tbl[i].eregs, 2'b00});
    end

    // SLEEP_REQ raised during reset release is ignored until ACTIVE
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    act_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, i < 2 ? 1'b0 : 1'b1, 1'b0, 1'b0, i >= 4, 1'b0);
      if (BUS_ACTIVE) act_cnt++;
    end
    chk("slpreq_active_cycles", 6'(act_cnt), 6'd1);
    chk("slpreq_back_asleep", 6'(MBC_SLEEP), 6'd1);

    // interrupt timeout with CIN held high
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    lows = 0; errs = 0; acks = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, i == 0);
      if (obs_dout === 1'b0) lows++;
      if (INT_ERR) errs++;
      if (INT_ACK) acks++;
    end
    chk("to_dout_low_cycles", 6'(lows), 6'(TO));
    chk("to_err_pulses", 6'(errs), 6'd1);
    chk("to_ack_pulses", 6'(acks), 6'd0);

    // master answers by pulling CIN low; ACK lands on the same edge the timeout would
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    acks = 0; errs = 0; ack_at = -1;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, i >= 6 ? 1'b0 : 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, i == 0);
      if (INT_ERR) errs++;
      if (INT_ACK) begin acks++; if (ack_at < 0) ack_at = i; end
    end
    chk("ack_pulses", 6'(acks), 6'd1);
    chk("ack_err_pulses", 6'(errs), 6'd0);
    chk("ack_latency", 6'((ack_at - 6 == 2) || (ack_at - 6 == 3)), 6'd1);
    chk("ack_dout_released", 6'(obs_dout), 6'd1);

    // RESET during ISO_SET while driving the interrupt
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("isoset_drive_low", 6'(obs_dout), 6'd0);
    chk("isoset_entered", 6'({MBC_ISOLATE, BUS_ACTIVE}), 6'b000010);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst_dout_released", 6'(obs_dout), 6'd1);
    chk("rst_regs", {MBC_SLEEP, MBC_RESET, MBC_ISOLATE, BUS_ACTIVE, INT_ACK, INT_ERR},
        6'b111000);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst_no_pulse", 6'({INT_ACK, INT_ERR}), 6'd0);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(63) == 0, $urandom_range(5) != 0, $urandom_range(7) != 0,
           bit'($urandom_range(1)), bit'($urandom_range(1)),
           $urandom_range(7) == 0, $urandom_range(7) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lname_mbus_member_ctrl.md
Name: lname_mbus_member_ctrl

Overview:
- Member-node counterpart of the MBus master controller; sits in the always-on domain of each member layer, between the bus wires and the power-gated bus controller.
- Sequences power-gating (sleep, reset, isolate) in response to bus wakeup (DIN pulled low) and local sleep requests.
- Forwards CIN/DIN around the gated controller while isolated.
- Implements member-initiated interrupt: holds DOUT low until the master starts clocking or a timeout expires.

Parameters:
- PG_DLY, 2, CLK cycles spent in each power-up/power-down stage (>=1).
- INT_TIMEOUT, 255, CLK cycles DOUT is held low awaiting a CIN low before giving up (>=1).

Ports:
- CLK  input  1  always-on sequencing clock
- RESET  input  1  synchronous, active-high reset
- CIN  input  1  raw bus clock in
- DIN  input  1  raw bus data in
- COUT_FROM_BUS  input  1  clock out from gated bus controller
- DOUT_FROM_BUS  input  1  data out from gated bus controller
- COUT  output  1  bus clock out
- DOUT  output  1  bus data out
- SLEEP_REQ  input  1  level sleep request from bus controller; honoured only in ACTIVE
- INT_REQ  input  1  level request from layer to wake bus
- MBC_SLEEP  output  1  power-gate enable, 1 = controller unpowered
- MBC_RESET  output  1  controller reset, 1 = held in reset
- MBC_ISOLATE  output  1  isolation, 1 = controller outputs isolated
- BUS_ACTIVE  output  1  1 only in state ACTIVE
- INT_ACK  output  1  one-cycle pulse: master responded to interrupt
- INT_ERR  output  1  one-cycle pulse: interrupt timed out

Behaviour:
- Reset values:
  - Synchronous, active-high RESET; all state updates on posedge CLK.
  - State SLEEP; MBC_SLEEP=1, MBC_RESET=1, MBC_ISOLATE=1; BUS_ACTIVE=0, INT_ACK=0, INT_ERR=0.
  - int_drive=0; counters 0.
- Synchronisers:
  - CIN and DIN pass through 2-flop synchronisers (cin_s, din_s) for all FSM decisions.
  - Synchroniser flops reset to 1.
  - Wire muxing uses the raw inputs.
- Power-up FSM:
  - SLEEP -> PWR_UP when din_s==0 or INT_REQ==1. MBC_SLEEP goes 0 on entry.
  - PWR_UP holds PG_DLY cycles -> RST_REL. MBC_RESET goes 0 on entry.
  - RST_REL holds PG_DLY cycles -> ISO_REL. MBC_ISOLATE goes 0 on entry.
  - ISO_REL holds 1 cycle -> ACTIVE.
  - Wake latency from din_s low to MBC_ISOLATE=0 is exactly 2*PG_DLY+1 CLK edges, plus 2 synchroniser cycles from raw DIN.
- Power-down FSM:
  - ACTIVE -> ISO_SET when SLEEP_REQ==1. MBC_ISOLATE goes 1 on entry.
  - ISO_SET holds PG_DLY cycles -> RST_SET. MBC_RESET goes 1 on entry.
  - RST_SET holds PG_DLY cycles -> SLEEP. MBC_SLEEP goes 1 on entry.
- FSM boundary cases:
  - SLEEP_REQ outside ACTIVE is ignored; no latching.
  - din_s low during ISO_SET/RST_SET does not abort. The sequence completes to SLEEP, then re-wakes on the next cycle if din_s is still low.
  - SLEEP_REQ and a wake condition never conflict: they are evaluated in disjoint states.
  - Stage counter: width clog2(PG_DLY+1). It clears on every state entry and never wraps.
- Interrupt:
  - int_drive sets when all hold: INT_REQ=1, int_drive=0, cin_s=1, din_s=1, and no INT_ACK/INT_ERR in the previous cycle.
  - Setting is allowed in any FSM state, so a sleeping layer both wakes itself and wakes the bus.
  - While int_drive=1: DOUT=0 regardless of other sources; timeout counter increments each cycle.
  - cin_s==0 while int_drive=1: clear int_drive, pulse INT_ACK. This check takes priority over timeout in the same cycle.
  - Counter reaches INT_TIMEOUT-1 with cin_s still 1: clear int_drive, pulse INT_ERR.
  - INT_REQ still high after an ACK/ERR re-arms only once the bus is idle again.
  - INT_REQ dropping while int_drive=1 does not release DOUT early.
- Wire control (combinational):
  - RESET=1 or MBC_ISOLATE=1: COUT=CIN, DOUT=DIN (bypass ring).
  - Otherwise: COUT=COUT_FROM_BUS, DOUT=DOUT_FROM_BUS.
  - int_drive overrides DOUT to 0 in every case except RESET=1.
- Reset mid-sequence: any state returns to SLEEP with full reset values on the next edge; DOUT is released immediately.

Test Plan:
- Reset then DIN=0 with PG_DLY=2: MBC_SLEEP falls 3 edges after DIN fall, MBC_RESET 2 edges later, MBC_ISOLATE 2 edges later, BUS_ACTIVE=1 one edge after that; COUT=CIN until isolate drops, then COUT=COUT_FROM_BUS.
- ACTIVE, SLEEP_REQ=1 for 1 cycle: MBC_ISOLATE=1 next edge, MBC_RESET +2, MBC_SLEEP +2; DOUT follows raw DIN once isolated.
- SLEEP_REQ asserted during RST_REL: ignored; FSM reaches ACTIVE; SLEEP_REQ held high then starts power-down from ACTIVE.
- In SLEEP, INT_REQ=1 with bus idle: DOUT=0 within 1 cycle and wake sequence starts; CIN driven low after 10 cycles -> INT_ACK single pulse 2-3 cycles later, DOUT released.
- INT_REQ=1, INT_TIMEOUT=8, CIN held 1: DOUT low exactly 8 cycles, then INT_ERR one-cycle pulse, INT_ACK stays 0.
- RESET asserted in ISO_SET with int_drive=1: next edge all MBC_*=1, BUS_ACTIVE=0, DOUT=DIN, no ACK/ERR pulse.
